uart_io_ctrl: RTL and testbench

- Memory-mapped controller between the J1 I/O bus and the buart byte transmitter/receiver.
- Decodes a 4-word register window and drains received bytes into an RX FIFO.
- Buffers CPU writes in a TX FIFO and sequences them into buart one byte at a time, honouring busy.
- Removes CPU polling of raw buart strobes and prevents lost TX bytes when the CPU writes while the transmitter is busy.

---
 rtl/uart_io_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_uart_io_ctrl.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_io_ctrl.sv
// J1 I/O bus controller for the buart: a 4-word register window, TX FIFO with a
// byte sequencer that honours busy, and an RX FIFO that drains received bytes.
module uart_io_ctrl #(
  parameter logic [15:0] BASE_ADDR = 16'h4000,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  output logic        uart_wr,
  output logic [7:0]  uart_tx_data,
  output logic        uart_rd,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_valid,
  input  logic        uart_busy
);

  localparam int TXW = $clog2(TX_DEPTH);
  localparam int RXW = $clog2(RX_DEPTH);
  localparam int TXC = TXW + 1;
  localparam int RXC = RXW + 1;

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} tx_state_t;

  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TXW-1:0] tx_wp, tx_rp;
  logic [TXC-1:0] tx_count;
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RXW-1:0] rx_wp, rx_rp;
  logic [RXC-1:0] rx_count;

  logic      rx_overrun, tx_overflow;
  tx_state_t tx_state;
  logic      wait_cnt;

  logic       in_win;
  logic [1:0] reg_sel;
  logic       rx_pop, tx_push_req, tx_push, stat_rd, ctrl_wr, flush, flag_clr;
  logic       tx_launch, rx_drain, rx_push;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic [4:0] tx_cnt5, rx_cnt5;
  logic [15:0] status, rd_data;
  logic       unused_io_dout;

  assign in_win  = (io_addr[15:2] == BASE_ADDR[15:2]);
  assign reg_sel = io_addr[1:0];

  assign tx_full  = (tx_count == TXC'(TX_DEPTH));
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == RXC'(RX_DEPTH));
  assign rx_empty = (rx_count == '0);

  assign rx_pop      = io_rd & in_win & (reg_sel == 2'd0) & ~rx_empty;
  assign tx_push_req = io_wr & in_win & (reg_sel == 2'd1);
  assign tx_push     = tx_push_req & ~tx_full;
  assign stat_rd     = io_rd & in_win & (reg_sel == 2'd2);
  assign ctrl_wr     = io_wr & in_win & (reg_sel == 2'd3);
  assign flush       = ctrl_wr & io_dout[0];
  assign flag_clr    = stat_rd | (ctrl_wr & io_dout[1]);

  assign tx_launch = (tx_state == IDLE) & ~tx_empty & ~uart_busy;
  // Skipping the cycle right after a strobe lets buart drop valid before we look again.
  assign rx_drain  = uart_valid & ~uart_rd;
  assign rx_push   = rx_drain & ~rx_full;

  assign unused_io_dout = ^io_dout[15:8];

  // Depths never exceed 16, so bit 4 set means exactly 16: clamp the 4-bit field.
  assign tx_cnt5 = 5'(tx_count);
  assign rx_cnt5 = 5'(rx_count);
  assign status = {(rx_cnt5[4] ? 4'hf : rx_cnt5[3:0]),
                   (tx_cnt5[4] ? 4'hf : tx_cnt5[3:0]),
                   2'b00, (tx_state != IDLE), tx_overflow, rx_overrun,
                   tx_empty, tx_full, ~rx_empty};

  always_comb begin
    rd_data = 16'h0000;
    if (in_win) begin
      case (reg_sel)
        2'd0:    rd_data = rx_empty ? 16'h0000 : {8'h00, rx_mem[rx_rp]};
        2'd2:    rd_data = status;
        default: rd_data = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      io_din <= 16'h0000;
    end else if (io_rd) begin
      io_din <= rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= io_dout[7:0];
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_count <= '0;
    end else if (flush) begin
      // A push in the flush cycle survives as the sole entry.
      tx_rp <= tx_wp;
      if (tx_push) begin
        tx_wp    <= tx_wp + 1'b1;
        tx_count <= TXC'(1);
      end else begin
        tx_count <= '0;
      end
    end else begin
      if (tx_push)   tx_wp <= tx_wp + 1'b1;
      if (tx_launch) tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_launch})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state     <= IDLE;
      wait_cnt     <= 1'b0;
      uart_wr      <= 1'b0;
      uart_tx_data <= 8'h00;
    end else begin
      uart_wr <= 1'b0;
      case (tx_state)
        IDLE: begin
          if (tx_launch) begin
            uart_wr      <= 1'b1;
            uart_tx_data <= tx_mem[tx_rp];
            wait_cnt     <= 1'b0;
            tx_state     <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          // Give buart two cycles to raise busy; a silent transmitter must not wedge us.
          if (uart_busy)     tx_state <= WAIT_DONE;
          else if (wait_cnt) tx_state <= IDLE;
          else               wait_cnt <= 1'b1;
        end
        WAIT_DONE: begin
          if (!uart_busy) tx_state <= IDLE;
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= uart_rx_data;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_count <= '0;
      uart_rd  <= 1'b0;
    end else begin
      uart_rd <= rx_drain;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // A set event in the clear cycle keeps the flag raised.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      rx_overrun  <= (rx_drain & rx_full) | (rx_overrun & ~flag_clr);
      tx_overflow <= (tx_push_req & tx_full) | (tx_overflow & ~flag_clr);
    end
  end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Randomized self-checking bench for uart_io_ctrl with behavioural buart models
// and a queue-based reference for FIFO contents and STATUS.
module tb_uart_io_ctrl;

  localparam logic [15:0] BASE = 16'h4000;
  localparam int TX_DEPTH = 8;
  localparam int RX_DEPTH = 4;

  logic        clk, resetq, io_rd, io_wr;
  logic [15:0] io_addr, io_dout, io_din;
  logic        uart_wr, uart_rd, uart_valid, uart_busy;
  logic [7:0]  uart_tx_data, uart_rx_data;

  int checks = 0;
  int errors = 0;

  uart_io_ctrl #(.BASE_ADDR(BASE), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
    .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
    .io_dout(io_dout), .io_din(io_din), .uart_wr(uart_wr), .uart_tx_data(uart_tx_data),
    .uart_rd(uart_rd), .uart_rx_data(uart_rx_data), .uart_valid(uart_valid),
    .uart_busy(uart_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // buart transmitter: busy for 10 cycles after each accepted strobe
  int busy_left = 0;
  bit busy_en = 1'b1;
  bit busy_force = 1'b0;
  always @(posedge clk) begin
    if (uart_wr && busy_en) busy_left <= 10;
    else if (busy_left > 0) busy_left <= busy_left - 1;
  end
  assign uart_busy = busy_force | (busy_left != 0);

  // buart receiver: byte source released by each uart_rd strobe
  logic [7:0] src_mem [0:63];
  int src_n = 0;
  int src_rd = 0;
  always @(posedge clk) if (uart_rd) src_rd <= src_rd + 1;
  assign uart_valid   = (src_rd < src_n);
  assign uart_rx_data = src_mem[src_rd[5:0]];

  // strobe monitor
  int cyc = 0;
  logic [7:0] tx_log [0:255];
  int tx_cyc [0:255];
  int tx_n = 0, rd_n = 0, busy_viol = 0, dbl_viol = 0;
  logic prev_wr = 1'b0, prev_rd = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (uart_wr) begin
      tx_log[tx_n[7:0]] <= uart_tx_data;
      tx_cyc[tx_n[7:0]] <= cyc;
      tx_n <= tx_n + 1;
      if (uart_busy) busy_viol <= busy_viol + 1;
    end
    if (uart_rd) rd_n <= rd_n + 1;
    if ((uart_wr && prev_wr) || (uart_rd && prev_rd)) dbl_viol <= dbl_viol + 1;
    prev_wr <= uart_wr;
    prev_rd <= uart_rd;
  end

  function automatic logic [15:0] exp_status(input int rxc, input bit ovr, input int txc,
                                             input bit ovf, input bit act);
    logic [15:0] s;
    s = 16'h0000;
    s[0] = (rxc > 0);
    s[1] = (txc == TX_DEPTH);
    s[2] = (txc == 0);
    s[3] = ovr;
    s[4] = ovf;
    s[5] = act;
    s[11:8]  = (txc > 15) ? 4'hf : 4'(txc);
    s[15:12] = (rxc > 15) ? 4'hf : 4'(rxc);
    return s;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    io_addr = a; io_dout = d; io_wr = 1'b1;
    @(negedge clk);
    io_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
    io_addr = a; io_rd = 1'b1;
    @(negedge clk);
    io_rd = 1'b0;
    d = io_din;
  endtask

  task automatic present(input logic [7:0] b);
    src_mem[src_n[5:0]] = b;
    src_n = src_n + 1;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    resetq = 1'b0;
    cycles(3);
    checks++;
    if (io_din !== 16'h0 || uart_wr !== 1'b0 || uart_rd !== 1'b0 || uart_tx_data !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs io_din=%h wr=%b rd=%b txd=%h required all zero",
               io_din, uart_wr, uart_rd, uart_tx_data);
    end
    resetq = 1'b1;
    cycles(2);
    cpu_read(BASE + 16'd2, d);
    checks++;
    if (d !== 16'h0004) begin errors++; $display("FAIL reset_status got %h expected 0004", d); end
    cycles(3);
    checks++;
    if (io_din !== 16'h0004) begin errors++; $display("FAIL io_din_hold got %h expected 0004", io_din); end
    // writes to read-only or foreign addresses must not push
    cpu_write(BASE + 16'd0, 16'h00aa);
    cpu_write(BASE + 16'd2, 16'h00bb);
    cpu_write(16'h4004, 16'h00cc);
    cpu_write(16'h3ffd, 16'h00dd);
    cpu_read(BASE + 16'd1, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL read_txreg got %h expected 0000", d); end
    cpu_read(BASE + 16'd2, d);
    checks++;
    if (d !== 16'h0004) begin errors++; $display("FAIL noop_status got %h expected 0004", d); end
    cpu_read(16'h4006, d);
    checks++;
    if (d !== 16'h0000) begin errors++; $display("FAIL outside_read got %h expected 0000", d); end
    cycles(20);
    checks++;
    if (tx_n !== 0 || rd_n !== 0) begin
      errors++; $display("FAIL reset_strobes wr=%0d rd=%0d expected 0 0", tx_n, rd_n);
    end
  endtask

  task automatic test_tx_basic();
    logic [7:0] exp [3];
    logic [15:0] d;
    int base;
    exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
    base = tx_n;
    for (int i = 0; i < 3; i++) cpu_write(BASE + 16'd1, {8'h00, exp[i]});
    for (int t = 0; t < 300 && tx_n < base + 3; t++) cycles(1);
    cycles(15);
    checks++;
    if (tx_n - base !== 3) begin errors++; $display("FAIL tx_basic_count got %0d expected 3", tx_n - base); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tx_log[base + i] !== exp[i]) begin
        errors++; $display("FAIL tx_basic_byte%0d got %h expected %h", i, tx_log[base + i], exp[i]);
      end
    end
    checks++;
    if (busy_viol !== 0) begin errors++; $display("FAIL tx_while_busy got %0d expected 0", busy_viol); end
    cpu_read(BASE + 16'd2, d);
    checks++;
    if (d !== 16'h0004) begin errors++; $display("FAIL tx_basic_status got %h expected 0004", d); end
  endtask

  task automatic test_tx_timeout();
    logic [7:0] b0, b1;
    int base;
    busy_en = 1'b0;
    b0 = 8'($urandom); b1 = 8'($urandom);
    base = tx_n;
    cpu_write(BASE + 16'd1, {8'h00, b0});
    cpu_write(BASE + 16'd1, {8'h00, b1});
    for (int t = 0; t < 50 && tx_n < base + 2; t++) cycles(1);
    cycles(4);
    checks++;
    if (tx_n - base !== 2 || tx_log[base] !== b0 || tx_log[base + 1] !== b1) begin
      errors++; $display("FAIL timeout_bytes n=%0d got %h %h expected %h %h",
                         tx_n - base, tx_log[base], tx_log[base + 1], b0, b1);
    end
    checks++;
    if (tx_cyc[base + 1] - tx_cyc[base] !== 3) begin
      errors++; $display("FAIL timeout_spacing got %0d expected 3", tx_cyc[base + 1] - tx_cyc[base]);
    end
    busy_en = 1'b1;
    cycles(3);
  endtask

  task automatic test_tx_overflow();
    logic [15:0] d;
    int base;
    base = tx_n;
    busy_force = 1'b1;
    for (int i = 0; i < 9; i++) cpu_write(BASE + 16'd1, 16'($urandom_range(0, 255)));
    cpu_read(BASE + 16'd2, d);
    checks++;
    if (d !== 16'h0812) begin errors++; $display("FAIL ovf_status got %h expected 0812", d); end
    cpu_read(BASE + 16'd2, d);
    checks++;
    if (d !== 16'h0802) begin errors++; $display("FAIL ovf_cleared got %h expected 0802", d); end
    cpu_write(BASE + 16'd1, 16'h0077);
    cpu_write(BASE + 16'd3, 16'h0003);
    cpu_read(BASE + 16'd2, d);
    checks++;
    if (d !== 16'h0004) begin errors++; $display("FAIL ctrl_flush_clear got %h expected 0004", d); end
    checks++;
    if (tx_n !== base) begin errors++; $display("FAIL ovf_no_wr got %0d expected %0d", tx_n, base); end
    busy_force = 1'b0;
    cycles(5);
  endtask

  task automatic test_tx_random();
    logic [7:0] q [$];
    logic [7:0] b;
    logic [15:0] d, e;
    int n, base;
    for (int it = 0; it < 2; it++) begin
      q.delete();
      base = tx_n;
      busy_force = 1'b1;
      n = $urandom_range(1, 11);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        if (q.size() < TX_DEPTH) q.push_back(b);
        cpu_write(BASE + 16'd1, {8'h00, b});
      end
      e = exp_status(0, 1'b0, q.size(), n > TX_DEPTH, 1'b0);
      cpu_read(BASE + 16'd2, d);
      checks++;
      if (d !== e) begin errors++; $display("FAIL txrand_status n=%0d got %h expected %h", n, d, e); end
      busy_force = 1'b0;
      for (int t = 0; t < 20 * TX_DEPTH + 40 && tx_n < base + q.size(); t++) cycles(1);
      cycles(15);
      checks++;
      if (tx_n - base !== q.size()) begin
        errors++; $display("FAIL txrand_count got %0d expected %0d", tx_n - base, q.size());
      end
      for (int i = 0; i < q.size(); i++) begin
        checks++;
        if (tx_log[base + i] !== q[i]) begin
          errors++; $display("FAIL txrand_byte%0d got %h expected %h", i, tx_log[base + i], q[i]);
        end
      end
    end
  endtask

  task automatic test_rx_overrun();
    logic [7:0] q [$];
    logic [15:0] d, e;
    bit ovr;
    int base;
    ovr = 1'b0;
    base = rd_n;
    for (int i = 0; i < 5; i++) begin
      if (q.size() < RX_DEPTH) q.push_back(8'(8'h10 + i)); else ovr = 1'b1;
      present(8'(8'h10 + i));
    end
    cycles(14);
    checks++;
    if (rd_n - base !== 5) begin errors++; $display("FAIL rx_strobes got %0d expected 5", rd_n - base); end
    e = exp_status(q.size(), ovr, 0, 1'b0, 1'b0);
    cpu_read(BASE + 16'd2, d);
    checks++;
    if (d !== e || d !== 16'h400d) begin errors++; $display("FAIL rx_ovr_status got %h expected %h", d, e); end
    for (int i = 0; i < 5; i++) begin
      e = (i < q.size()) ? {8'h00, q[i]} : 16'h0000;
      cpu_read(BASE + 16'd0, d);
      checks++;
      if (d !== e) begin errors++; $display("FAIL rx_read%0d got %h expected %h", i, d, e); end
    end
    cpu_read(BASE + 16'd2, d);
    checks++;
    if (d !== 16'h0004) begin errors++; $display("FAIL rx_empty_status got %h expected 0004", d); end
  endtask

  task automatic test_rx_same_cycle();
    logic [7:0] b1, b2;
    logic [7:0] q [$];
    logic [15:0] d;
    b1 = 8'($urandom); b2 = 8'($urandom);
    present(b1);
    cycles(4);
    // new byte arrives in the very cycle the CPU pops the old one
    present(b2);
    cpu_read(BASE + 16'd0, d);
    checks++;
    if (d !== {8'h00, b1}) begin errors++; $display("FAIL same_pop_old got %h expected %h", d, {8'h00, b1}); end
    cycles(3);
    cpu_read(BASE + 16'd2, d);
    checks++;
    if (d !== exp_status(1, 1'b0, 0, 1'b0, 1'b0)) begin
      errors++; $display("FAIL same_count got %h expected %h", d, exp_status(1, 1'b0, 0, 1'b0, 1'b0));
    end
    cpu_read(BASE + 16'd0, d);
    checks++;
    if (d !== {8'h00, b2}) begin errors++; $display("FAIL same_pop_new got %h expected %h", d, {8'h00, b2}); end
    for (int i = 0; i < RX_DEPTH; i++) begin
      q.push_back(8'($urandom));
      present(q[i]);
    end
    cycles(2 * RX_DEPTH + 3);
    // overrun set and STATUS clear land on the same edge
    present(8'($urandom));
    cpu_read(BASE + 16'd2, d);
    checks++;
    if (d !== exp_status(RX_DEPTH, 1'b0, 0, 1'b0, 1'b0)) begin
      errors++; $display("FAIL race_pre got %h expected %h", d, exp_status(RX_DEPTH, 1'b0, 0, 1'b0, 1'b0));
    end
    cycles(2);
    cpu_read(BASE + 16'd2, d);
    checks++;
    if (d !== exp_status(RX_DEPTH, 1'b1, 0, 1'b0, 1'b0)) begin
      errors++; $display("FAIL race_kept got %h expected %h", d, exp_status(RX_DEPTH, 1'b1, 0, 1'b0, 1'b0));
    end
    cpu_read(BASE + 16'd2, d);
    checks++;
    if (d !== exp_status(RX_DEPTH, 1'b0, 0, 1'b0, 1'b0)) begin
      errors++; $display("FAIL race_clear got %h expected %h", d, exp_status(RX_DEPTH, 1'b0, 0, 1'b0, 1'b0));
    end
    for (int i = 0; i < RX_DEPTH; i++) begin
      cpu_read(BASE + 16'd0, d);
      checks++;
      if (d !== {8'h00, q[i]}) begin errors++; $display("FAIL race_data%0d got %h expected %h", i, d, {8'h00, q[i]}); end
    end
  endtask

  task automatic test_rx_random();
    logic [7:0] q [$];
    logic [7:0] b;
    logic [15:0] d, e;
    bit ovr;
    int n;
    for (int it = 0; it < 2; it++) begin
      q.delete();
      ovr = 1'b0;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        if (q.size() < RX_DEPTH) q.push_back(b); else ovr = 1'b1;
        present(b);
      end
      cycles(2 * n + 4);
      e = exp_status(q.size(), ovr, 0, 1'b0, 1'b0);
      cpu_read(BASE + 16'd2, d);
      checks++;
      if (d !== e) begin errors++; $display("FAIL rxrand_status n=%0d got %h expected %h", n, d, e); end
      for (int i = 0; i <= q.size(); i++) begin
        e = (i < q.size()) ? {8'h00, q[i]} : 16'h0000;
        cpu_read(BASE + 16'd0, d);
        checks++;
        if (d !== e) begin errors++; $display("FAIL rxrand_read%0d got %h expected %h", i, d, e); end
      end
    end
  endtask

  task automatic test_flush_mid();
    logic [7:0] b [4];
    logic [15:0] d;
    int base;
    cycles(15);
    base = tx_n;
    b[0] = 8'($urandom_range(1, 255));
    for (int i = 1; i < 4; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) cpu_write(BASE + 16'd1, {8'h00, b[i]});
    cycles(2);
    cpu_read(BASE + 16'd2, d);
    checks++;
    if (d !== exp_status(0, 1'b0, 3, 1'b0, 1'b1)) begin
      errors++; $display("FAIL flush_pre got %h expected %h", d, exp_status(0, 1'b0, 3, 1'b0, 1'b1));
    end
    cpu_write(BASE + 16'd3, 16'h0001);
    cpu_read(BASE + 16'd2, d);
    checks++;
    if (d !== exp_status(0, 1'b0, 0, 1'b0, 1'b1)) begin
      errors++; $display("FAIL flush_active got %h expected %h", d, exp_status(0, 1'b0, 0, 1'b0, 1'b1));
    end
    cycles(30);
    checks++;
    if (tx_n - base !== 1 || tx_log[base] !== b[0]) begin
      errors++; $display("FAIL flush_wr n=%0d byte=%h expected 1 %h", tx_n - base, tx_log[base], b[0]);
    end
    cpu_read(BASE + 16'd2, d);
    checks++;
    if (d !== 16'h0004) begin errors++; $display("FAIL flush_post got %h expected 0004", d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b0;
    logic [15:0] d;
    int base;
    base = tx_n;
    b0 = 8'($urandom_range(1, 255));
    cpu_write(BASE + 16'd1, {8'h00, b0});
    cpu_write(BASE + 16'd1, 16'($urandom_range(0, 255)));
    cpu_write(BASE + 16'd1, 16'($urandom_range(0, 255)));
    cycles(3);
    cpu_read(BASE + 16'd2, d);
    checks++;
    if (d !== exp_status(0, 1'b0, 2, 1'b0, 1'b1)) begin
      errors++; $display("FAIL rstmid_pre got %h expected %h", d, exp_status(0, 1'b0, 2, 1'b0, 1'b1));
    end
    #2 resetq = 1'b0;
    #1;
    checks++;
    if (io_din !== 16'h0 || uart_wr !== 1'b0 || uart_rd !== 1'b0 || uart_tx_data !== 8'h0) begin
      errors++; $display("FAIL rstmid_async io_din=%h wr=%b rd=%b txd=%h required all zero",
                         io_din, uart_wr, uart_rd, uart_tx_data);
    end
    @(negedge clk);
    cycles(1);
    resetq = 1'b1;
    cycles(15);
    cpu_read(BASE + 16'd2, d);
    checks++;
    if (d !== 16'h0004) begin errors++; $display("FAIL rstmid_status got %h expected 0004", d); end
    checks++;
    if (tx_n - base !== 1) begin errors++; $display("FAIL rstmid_wr got %0d expected 1", tx_n - base); end
  endtask

  task automatic test_strobe_rules();
    checks++;
    if (dbl_viol !== 0 || busy_viol !== 0) begin
      errors++; $display("FAIL strobe_rules back_to_back=%0d while_busy=%0d expected 0 0", dbl_viol, busy_viol);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    io_rd = 1'b0; io_wr = 1'b0; io_addr = 16'h0; io_dout = 16'h0;
    for (int i = 0; i < 64; i++) src_mem[i] = 8'h00;
    resetq = 1'b0;
    @(negedge clk);
    test_reset();
    test_tx_basic();
    test_tx_timeout();
    test_tx_overflow();
    test_tx_random();
    test_rx_overrun();
    test_rx_same_cycle();
    test_rx_random();
    test_flush_mid();
    test_reset_mid();
    test_strobe_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
